// File: rtl/phy_tx_stim_chk.sv
// Stimulus generator and twin-output checker for a phy_tx behavioural/synth pair.
// Runs on the fastest clock. The slower rates appear as single-cycle enable strobes.
// A scripted phase sequence drives the pair, and per-lane serial outputs plus the
// recirculation word are compared against their synthesized twins.
module phy_tx_stim_chk #(
    parameter int                 DATA_W  = 32,
    parameter int                 LANES   = 2,
    parameter int                 N_HOLD  = 2,
    parameter int                 N_RST   = 5,
    parameter int                 N_REC   = 10,
    parameter int                 N_FULL  = 35,
    parameter int                 N_RAND  = 20,
    parameter logic [DATA_W-1:0]  INC_RST = DATA_W'(32'h0321AE4F),
    parameter logic [DATA_W-1:0]  INC_REC = DATA_W'(32'h320FE14F),
    parameter logic [DATA_W-1:0]  INC_DAT = DATA_W'(32'h002F190A)
) (
    input  logic              clk_32f,
    input  logic              reset,
    input  logic              start,
    output logic              en_f,
    output logic              en_2f,
    output logic              en_4f,
    output logic              reset_L,
    output logic              valid_in,
    output logic [DATA_W-1:0] data_in,
    output logic [LANES-1:0]  active_lane,
    input  logic [LANES-1:0]  data_out_lane,
    input  logic [LANES-1:0]  data_out_lane_synth,
    input  logic [DATA_W-1:0] data_out_Recirc_Retorno,
    input  logic [DATA_W-1:0] data_out_Recirc_Retorno_synth,
    output logic [2:0]        phase,
    output logic              busy,
    output logic              done,
    output logic [15:0]       err_cnt,
    output logic [2:0]        err_phase
);

    typedef enum logic [2:0] {
        PH_IDLE = 3'd0,
        PH_HOLD = 3'd1,
        PH_RST  = 3'd2,
        PH_REC  = 3'd3,
        PH_FULL = 3'd4,
        PH_RAND = 3'd5,
        PH_DONE = 3'd6
    } phase_t;

    logic [4:0]        div_reg;
    logic [4:0]        div_next;
    logic              en_f_reg, en_2f_reg, en_4f_reg;
    phase_t            state_reg;
    phase_t            state_next;
    logic [15:0]       scnt_reg;
    logic [15:0]       len_m1;
    logic              reset_l_reg;
    logic              valid_reg;
    logic [DATA_W-1:0] data_reg;
    logic [LANES-1:0]  active_reg;
    logic [15:0]       err_cnt_reg;
    logic [2:0]        err_phase_reg;
    logic [LANES-1:0]  lane_miss;
    logic              chk_active;
    logic              miss_event;

    assign div_next = div_reg + 5'd1;

    // Free-running divider; strobes are registered one cycle ahead so each one
    // is high exactly while div holds its terminal value.
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            div_reg   <= '0;
            en_f_reg  <= 1'b0;
            en_2f_reg <= 1'b0;
            en_4f_reg <= 1'b0;
        end else begin
            div_reg   <= div_next;
            en_4f_reg <= (div_next[2:0] == 3'd7);
            en_2f_reg <= (div_next[3:0] == 4'd15);
            en_f_reg  <= (div_next == 5'd31);
        end
    end

    // Phase length and successor for the phase currently being played.
    always_comb begin
        len_m1     = '0;
        state_next = state_reg;
        case (state_reg)
            PH_HOLD: begin len_m1 = 16'(N_HOLD - 1); state_next = PH_RST;  end
            PH_RST:  begin len_m1 = 16'(N_RST - 1);  state_next = PH_REC;  end
            PH_REC:  begin len_m1 = 16'(N_REC - 1);  state_next = PH_FULL; end
            PH_FULL: begin len_m1 = 16'(N_FULL - 1); state_next = PH_RAND; end
            PH_RAND: begin len_m1 = 16'(N_RAND - 1); state_next = PH_DONE; end
            default: begin len_m1 = '0;              state_next = state_reg; end
        endcase
    end

    // Sequencer: start is only honoured when idle or finished; otherwise all
    // phase advances and stimulus updates happen on en_2f.
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            state_reg   <= PH_IDLE;
            scnt_reg    <= '0;
            reset_l_reg <= 1'b0;
            valid_reg   <= 1'b0;
            data_reg    <= '0;
            active_reg  <= '0;
        end else begin
            case (state_reg)
                PH_IDLE, PH_DONE: begin
                    if (start) begin
                        state_reg <= PH_HOLD;
                        scnt_reg  <= '0;
                        data_reg  <= '0;
                    end
                end
                default: begin
                    if (en_2f_reg) begin
                        if (scnt_reg == len_m1) begin
                            scnt_reg  <= '0;
                            state_reg <= state_next;
                        end else begin
                            scnt_reg <= scnt_reg + 16'd1;
                        end
                        case (state_reg)
                            PH_HOLD: reset_l_reg <= 1'b0;
                            PH_RST: begin
                                reset_l_reg <= 1'b1;
                                data_reg    <= data_reg + INC_RST;
                                valid_reg   <= 1'b0;
                                active_reg  <= '0;
                            end
                            PH_REC: begin
                                reset_l_reg <= 1'b1;
                                data_reg    <= data_reg + INC_REC;
                                valid_reg   <= 1'b0;
                                active_reg  <= '0;
                            end
                            PH_FULL: begin
                                data_reg   <= data_reg + INC_DAT;
                                valid_reg  <= 1'b1;
                                active_reg <= {LANES{1'b1}};
                            end
                            PH_RAND: begin
                                // Pseudo-random valid taken from the pre-update data word.
                                data_reg   <= data_reg + INC_DAT;
                                valid_reg  <= data_reg[3];
                                active_reg <= {LANES{1'b1}};
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane_cmp
            assign lane_miss[gi] = data_out_lane[gi] ^ data_out_lane_synth[gi];
        end
    endgenerate

    assign chk_active = (state_reg == PH_RST) || (state_reg == PH_REC) ||
                        (state_reg == PH_FULL) || (state_reg == PH_RAND);
    // Lane and recirculation mismatches in one cycle collapse into a single event.
    assign miss_event = (|lane_miss) ||
                        (en_f_reg && (data_out_Recirc_Retorno != data_out_Recirc_Retorno_synth));

    // Saturating mismatch counter; the phase of the first event is latched.
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            err_cnt_reg   <= '0;
            err_phase_reg <= '0;
        end else if (chk_active && miss_event) begin
            if (err_cnt_reg != 16'hFFFF)
                err_cnt_reg <= err_cnt_reg + 16'd1;
            if (err_cnt_reg == 16'd0)
                err_phase_reg <= state_reg;
        end
    end

    assign en_f        = en_f_reg;
    assign en_2f       = en_2f_reg;
    assign en_4f       = en_4f_reg;
    assign reset_L     = reset_l_reg;
    assign valid_in    = valid_reg;
    assign data_in     = data_reg;
    assign active_lane = active_reg;
    assign phase       = state_reg;
    assign busy        = (state_reg != PH_IDLE) && (state_reg != PH_DONE);
    assign done        = (state_reg == PH_DONE);
    assign err_cnt     = err_cnt_reg;
    assign err_phase   = err_phase_reg;

endmodule

// File: tb/tb_phy_tx_stim_chk.sv
// Bench for phy_tx_stim_chk: cycle-level reference model plus directed checks,
// and a second single-lane instance driven into counter saturation.
module tb_phy_tx_stim_chk;

    localparam int DW = 32;
    localparam int LN = 2;
    localparam logic [DW-1:0] INC_RST = 32'h0321AE4F;
    localparam logic [DW-1:0] INC_REC = 32'h320FE14F;
    localparam logic [DW-1:0] INC_DAT = 32'h002F190A;
    // Cumulative strobe boundaries of HOLD/RST/REC/FULL/RAND (2,5,10,35,20).
    localparam int B_HOLD = 2, B_RST = 7, B_REC = 17, B_FULL = 52, B_RAND = 72;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, start;
    logic          en_f, en_2f, en_4f, reset_L, valid_in, busy, done;
    logic [DW-1:0] data_in, rec, rec_s;
    logic [LN-1:0] active_lane, lane, lane_s;
    logic [2:0]    phase, err_phase;
    logic [15:0]   err_cnt;

    logic          s_reset, s_start, s_lane, s_lane_s;
    logic          s_en_f, s_en_2f, s_en_4f, s_reset_L, s_valid, s_active, s_busy, s_done;
    logic [DW-1:0] s_data, s_rec;
    logic [2:0]    s_phase, s_err_phase;
    logic [15:0]   s_err_cnt;

    phy_tx_stim_chk dut (
        .clk_32f(clk), .reset(reset), .start(start),
        .en_f(en_f), .en_2f(en_2f), .en_4f(en_4f),
        .reset_L(reset_L), .valid_in(valid_in), .data_in(data_in), .active_lane(active_lane),
        .data_out_lane(lane), .data_out_lane_synth(lane_s),
        .data_out_Recirc_Retorno(rec), .data_out_Recirc_Retorno_synth(rec_s),
        .phase(phase), .busy(busy), .done(done), .err_cnt(err_cnt), .err_phase(err_phase)
    );

    phy_tx_stim_chk #(.LANES(1), .N_HOLD(1), .N_RST(1), .N_REC(1), .N_FULL(4200), .N_RAND(1)) sat (
        .clk_32f(clk), .reset(s_reset), .start(s_start),
        .en_f(s_en_f), .en_2f(s_en_2f), .en_4f(s_en_4f),
        .reset_L(s_reset_L), .valid_in(s_valid), .data_in(s_data), .active_lane(s_active),
        .data_out_lane(s_lane), .data_out_lane_synth(s_lane_s),
        .data_out_Recirc_Retorno(s_rec), .data_out_Recirc_Retorno_synth(s_rec),
        .phase(s_phase), .busy(s_busy), .done(s_done), .err_cnt(s_err_cnt), .err_phase(s_err_phase)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int            m_k, m_state, m_j, m_err, m_errph;
    logic [DW-1:0] m_data;
    logic          m_valid, m_rstl;
    logic [LN-1:0] m_active;
    int            g_cyc = 0;

    function automatic int phase_of(input int j);
        if (j < B_HOLD) return 1;
        if (j < B_RST)  return 2;
        if (j < B_REC)  return 3;
        if (j < B_FULL) return 4;
        if (j < B_RAND) return 5;
        return 6;
    endfunction

    function automatic int cur_phase();
        if (m_state == 0) return 0;
        if (m_state == 2) return 6;
        return phase_of(m_j);
    endfunction

    always @(posedge clk) begin
        int  ph;
        bit  miss;
        g_cyc++;
        if (reset) begin
            m_k = 0; m_state = 0; m_j = 0; m_err = 0; m_errph = 0;
            m_data = '0; m_valid = 1'b0; m_rstl = 1'b0; m_active = '0;
        end else begin
            ph = cur_phase();
            if (ph >= 2 && ph <= 5) begin
                miss = (lane != lane_s) || ((m_k % 32 == 31) && (rec != rec_s));
                if (miss) begin
                    if (m_err == 0) m_errph = ph;
                    if (m_err < 65535) m_err++;
                end
            end
            if (m_state != 1 && start) begin
                m_state = 1; m_j = 0; m_data = '0;
            end else if (m_state == 1 && (m_k % 16 == 15)) begin
                case (ph)
                    1: m_rstl = 1'b0;
                    2: begin m_rstl = 1'b1; m_data += INC_RST; m_valid = 1'b0; m_active = '0; end
                    3: begin m_rstl = 1'b1; m_data += INC_REC; m_valid = 1'b0; m_active = '0; end
                    4: begin m_data += INC_DAT; m_valid = 1'b1; m_active = '1; end
                    default: begin m_valid = m_data[3]; m_data += INC_DAT; m_active = '1; end
                endcase
                m_j++;
                if (m_j == B_RAND) m_state = 2;
            end
            m_k++;
        end
    end

    // ---------------- per-cycle compare ----------------
    bit chk_en = 0;
    int busy_strobes = 0;
    always @(negedge clk) begin
        int ph;
        if (chk_en) begin
            ph = cur_phase();
            chk("en_4f", 64'(en_4f), 64'(m_k % 8 == 7));
            chk("en_2f", 64'(en_2f), 64'(m_k % 16 == 15));
            chk("en_f", 64'(en_f), 64'(m_k % 32 == 31));
            chk("phase", 64'(phase), 64'(ph));
            chk("busy", 64'(busy), 64'(ph >= 1 && ph <= 5));
            chk("done", 64'(done), 64'(ph == 6));
            chk("reset_L", 64'(reset_L), 64'(m_rstl));
            chk("valid_in", 64'(valid_in), 64'(m_valid));
            chk("data_in", 64'(data_in), 64'(m_data));
            chk("active_lane", 64'(active_lane), 64'(m_active));
            chk("err_cnt", 64'(err_cnt), 64'(m_err));
            chk("err_phase", 64'(err_phase), 64'(m_errph));
            if (busy && en_2f) busy_strobes++;
        end
    end

    // Random lane/recirc traffic; the synth copies follow except where flipped.
    logic [LN-1:0] lane_flip = '0;
    logic [DW-1:0] rec_flip  = '0;
    always @(posedge clk) begin
        #2;
        lane   = LN'($urandom);
        rec    = $urandom;
        lane_s = lane ^ lane_flip;
        rec_s  = rec ^ rec_flip;
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_j(input int j, input string nm);
        int n = 0;
        while (m_j < j && n < 3000) begin @(negedge clk); n++; end
        if (m_j < j) begin
            n_vec++; n_bad++;
            $display("FAIL %s: timeout, strobe index %0d, required %0d", nm, m_j, j);
        end
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        @(negedge clk);
        while (!done && n < 3000) begin @(negedge clk); n++; end
        chk(nm, 64'(done), 64'd1);
    endtask

    initial begin
        int c2, cf, first2;
        reset = 1'b1; start = 1'b0; lane = '0; lane_s = '0; rec = '0; rec_s = '0;
        s_reset = 1'b1; s_start = 1'b0; s_lane = 1'b0; s_lane_s = 1'b1; s_rec = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0; s_reset = 1'b0; chk_en = 1;
        chk("reset_phase", 64'(phase), 64'd0);
        chk("reset_err", 64'(err_cnt), 64'd0);
        $display("reset released, idle cadence check");

        // Strobe cadence over the first 64 cycles
        c2 = 0; cf = 0; first2 = -1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (i == 1) s_start = 1'b1;
            if (i == 2) s_start = 1'b0;
            if (en_2f) begin c2++; if (first2 < 0) first2 = i; end
            if (en_f) cf++;
        end
        chk("cadence_en2f_count", 64'(c2), 64'd4);
        chk("cadence_en_f_count", 64'(cf), 64'd2);
        chk("cadence_first_en2f", 64'(first2), 64'd15);

        // Full sequence with lane and recirculation mismatch injection
        pulse_start();
        busy_strobes = 0;
        $display("sequence 1 started");
        wait_j(B_RST, "reach_end_rst");
        chk("data_end_rst", 64'(data_in), 64'h0FA8678B);
        wait_j(B_REC, "reach_full");
        chk("valid_before_full", 64'(valid_in), 64'd0);
        wait_j(20, "reach_inject");
        @(posedge clk); #1 lane_flip = 2'b10;
        repeat (3) @(posedge clk);
        #1 lane_flip = '0;
        repeat (4) @(negedge clk);
        chk("lane_err_cnt", 64'(err_cnt), 64'd3);
        chk("lane_err_phase", 64'(err_phase), 64'd4);
        $display("lane mismatch injected, err_cnt=%0d", err_cnt);
        do begin @(posedge clk); #1; end while (m_k % 32 != 0);
        rec_flip = 32'h0000_0100;
        repeat (32) @(posedge clk);
        #1 rec_flip = '0;
        repeat (3) @(negedge clk);
        chk("recirc_err_cnt", 64'(err_cnt), 64'd4);
        $display("recirc mismatch injected, err_cnt=%0d", err_cnt);
        wait_j(B_FULL, "reach_rand");
        chk("valid_end_full", 64'(valid_in), 64'd1);
        chk("active_end_full", 64'(active_lane), 64'(2'b11));
        wait_done("seq1_done");
        chk("seq1_strobes", 64'(busy_strobes), 64'd72);
        $display("sequence 1 done after %0d strobes", busy_strobes);

        // Restart keeps err state; start while busy ignored; reset in REC aborts
        pulse_start();
        $display("sequence 2 started");
        chk("restart_err_kept", 64'(err_cnt), 64'd4);
        wait_j(10, "reach_rec");
        pulse_start();
        chk("start_ignored_phase", 64'(phase), 64'd3);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("abort_phase", 64'(phase), 64'd0);
        chk("abort_reset_L", 64'(reset_L), 64'd0);
        chk("abort_data", 64'(data_in), 64'd0);
        chk("abort_err", 64'(err_cnt), 64'd0);
        $display("reset mid-REC applied");

        pulse_start();
        busy_strobes = 0;
        $display("sequence 3 started");
        wait_j(B_RST, "seq3_end_rst");
        chk("seq3_data_end_rst", 64'(data_in), 64'h0FA8678B);
        wait_done("seq3_done");
        chk("seq3_strobes", 64'(busy_strobes), 64'd72);
        chk("seq3_err", 64'(err_cnt), 64'd0);
        $display("sequence 3 done");

        // Saturation instance has been mismatching on every active cycle
        while (g_cyc < 66300) @(posedge clk);
        @(negedge clk);
        chk("sat_err_cnt", 64'(s_err_cnt), 64'hFFFF);
        chk("sat_phase", 64'(s_phase), 64'd4);
        chk("sat_err_phase", 64'(s_err_phase), 64'd2);
        $display("saturation instance err_cnt=%0h", s_err_cnt);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
